// File: rtl/dma_bus_arbiter_pkg.sv
// rtl/dma_bus_arbiter_pkg.sv - shared state encodings and width helper for the DMA bus arbiter
package dma_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_HANDOFF  = 3'd1,
    ARB_GRANT    = 3'd2,
    ARB_RETURN   = 3'd3,
    ARB_CPU_SLOT = 3'd4
  } arb_state_t;

  // Index width that stays at least one bit even for degenerate counts.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// rtl/dma_bus_arbiter_if.sv - request/grant bundle between DMA channels, CPU cache and the arbiter
interface dma_bus_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  import dma_bus_arbiter_pkg::*;

  localparam int OW = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] br;
  logic              cpu_mem_busy;
  logic              steal_mode;
  logic [NUM_CH-1:0] bg;
  logic              bus_release;
  logic [OW-1:0]     owner;
  logic              owner_valid;
  logic [CNT_W-1:0]  grant_cnt;

  modport master (
    input  br, cpu_mem_busy, steal_mode,
    output bg, bus_release, owner, owner_valid, grant_cnt
  );

  modport slave (
    output br, cpu_mem_busy, steal_mode,
    input  bg, bus_release, owner, owner_valid, grant_cnt
  );

endinterface

// File: rtl/dma_bus_arbiter_rr_picker.sv
// rtl/dma_bus_arbiter_rr_picker.sv - combinational round-robin winner search starting after last
module rr_picker
  import dma_bus_arbiter_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int OW     = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [OW-1:0]     last,
  output logic [OW-1:0]     win,
  output logic              any
);

  int idx;

  // Scan from the farthest candidate back to last+1 so the nearest requester is written last and wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = (int'(last) + i) % NUM_CH;
      if (req[idx]) begin
        win = OW'(idx);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - round-robin DMA bus arbiter with release/grant handoff and cycle stealing
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOTS = 4,
  parameter int CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  dma_bus_arbiter_if.master bus
);

  localparam int OW = clog2_min1(NUM_CH);
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam int SW = $clog2(CPU_SLOTS) + 1;

  arb_state_t        state, state_d;
  logic [OW-1:0]     owner_q, owner_d, last_owner, win;
  logic              pick_any;
  logic              steal_q, slot_pending;
  logic [BW-1:0]     burst_cnt;
  logic [SW-1:0]     slot_cnt;
  logic [CNT_W-1:0]  grant_cnt;
  logic [NUM_CH-1:0] bg_d;
  logic              release_d;
  logic              owner_br, burst_done, slots_done;

  rr_picker #(.NUM_CH(NUM_CH)) u_pick (
    .req  (bus.br),
    .last (last_owner),
    .win  (win),
    .any  (pick_any)
  );

  assign owner_br   = bus.br[owner_q];
  assign burst_done = steal_q && (burst_cnt == BW'(MAX_BURST - 1));
  assign slots_done = (slot_cnt == SW'(CPU_SLOTS - 1));

  always_ff @(posedge Clk) begin
    if (Reset) state <= ARB_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ARB_IDLE:     if (pick_any && !bus.cpu_mem_busy) state_d = ARB_HANDOFF;
      ARB_HANDOFF:  state_d = owner_br ? ARB_GRANT : ARB_RETURN;
      ARB_GRANT:    if (!owner_br || burst_done) state_d = ARB_RETURN;
      ARB_RETURN:   state_d = slot_pending ? ARB_CPU_SLOT : ARB_IDLE;
      ARB_CPU_SLOT: if (slots_done) state_d = ARB_IDLE;
      default:      state_d = ARB_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state they describe.
  always_comb begin
    owner_d = (state == ARB_IDLE && state_d == ARB_HANDOFF) ? win : owner_q;
    bg_d    = '0;
    if (state_d == ARB_GRANT) bg_d[owner_d] = 1'b1;
    release_d = (state_d == ARB_HANDOFF) || (state_d == ARB_GRANT) || (state_d == ARB_RETURN);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      owner_q         <= '0;
      last_owner      <= OW'(NUM_CH - 1);
      steal_q         <= 1'b0;
      slot_pending    <= 1'b0;
      burst_cnt       <= '0;
      slot_cnt        <= '0;
      grant_cnt       <= '0;
      bus.bg          <= '0;
      bus.bus_release <= 1'b0;
      bus.owner_valid <= 1'b0;
    end else begin
      owner_q         <= owner_d;
      bus.bg          <= bg_d;
      bus.bus_release <= release_d;
      bus.owner_valid <= release_d;
      case (state)
        ARB_IDLE: if (state_d == ARB_HANDOFF) begin
          steal_q      <= bus.steal_mode;
          slot_pending <= 1'b0;
        end
        ARB_HANDOFF: begin
          burst_cnt <= '0;
          if (state_d == ARB_GRANT) grant_cnt <= grant_cnt + CNT_W'(1);
        end
        ARB_GRANT: begin
          burst_cnt <= burst_cnt + BW'(1);
          // Leaving with the request still up can only mean the burst limit fired.
          if (state_d == ARB_RETURN) slot_pending <= owner_br;
        end
        ARB_RETURN: begin
          last_owner <= owner_q;
          slot_cnt   <= '0;
        end
        ARB_CPU_SLOT: slot_cnt <= slot_cnt + SW'(1);
        default: ;
      endcase
    end
  end

  assign bus.owner     = owner_q;
  assign bus.grant_cnt = grant_cnt;

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Multi-channel successor to the single-requester BR/BG grant logic in the CPU top. It arbitrates `NUM_CH` DMA engines for the shared data-memory bus and hands ownership between the CPU cache and the winning channel through an explicit release/grant sequence. Arbitration is round-robin. An optional cycle-stealing mode bounds the length of each DMA burst and guarantees the CPU bus slots in between. It sits beside the CPU/cache boundary; `bus_release` replaces BR as the tristate enable on the CPU's `d_*` drivers.

## Interface
Parameters:
- `NUM_CH`, 4: number of DMA requesters (≥2).
- `MAX_BURST`, 16: GRANT cycles allowed per tenure in steal mode (≥1).
- `CPU_SLOTS`, 4: forced CPU-ownership cycles after a burst-limit release (≥1).
- `CNT_W`, 16: width of the grant counter.

Ports:
- `Clk`  in  1  single clock; all logic is posedge.
- `Reset`  in  1  synchronous, active-high.
- `br`  in  NUM_CH  bus requests, one per channel; level-held.
- `cpu_mem_busy`  in  1  the cache has an outstanding memory transaction; no handoff while high.
- `steal_mode`  in  1  0 = burst mode (hold until BR drops), 1 = cycle-stealing (limit MAX_BURST).
- `bg`  out  NUM_CH  one-hot bus grant, registered.
- `bus_release`  out  1  the CPU must tristate `d_readM`/`d_writeM`/`d_address`/`d_data`.
- `owner`  out  clog2(NUM_CH)  index of the current or pending channel.
- `owner_valid`  out  1  `owner` is meaningful (HANDOFF/GRANT/RETURN).
- `grant_cnt`  out  CNT_W  count of grants issued; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, HANDOFF, GRANT, RETURN, CPU_SLOT. Every output is registered.
- IDLE: the CPU owns the bus. If any `br` is set and `cpu_mem_busy`=0, the block picks the winner by round-robin, searching from `(last_owner+1) mod NUM_CH`. It latches `owner`, latches `steal_mode` into `steal_q`, and moves to HANDOFF.
- HANDOFF: `bus_release`=1 and `bg`=0 for exactly one cycle. If `br[owner]` is still 1, go to GRANT and increment `grant_cnt`. Otherwise go to RETURN.
- GRANT: `bg[owner]`=1 and `bus_release`=1. `burst_cnt` increments each GRANT cycle.
  - If `br[owner]` drops, go to RETURN.
  - Else if `steal_q` is set and `burst_cnt`==MAX_BURST-1, go to RETURN with `slot_pending`=1.
- RETURN: `bg`=0 and `bus_release`=1 for one cycle. `last_owner` ← `owner`. Next state is CPU_SLOT if `slot_pending` is set, else IDLE.
- CPU_SLOT: `bus_release`=0. Hold for CPU_SLOTS cycles and ignore `br`, then go to IDLE.
- `br` from non-owner channels is ignored outside IDLE. A channel that loses re-arbitrates at the next IDLE.
- Changes to `steal_mode` mid-tenure have no effect until the next HANDOFF.
- Reset value of every output is 0. After reset, `last_owner`=NUM_CH-1, so channel 0 has first priority.

## Timing
- Request to grant, IDLE and not busy: `br` seen at edge N → `bus_release`=1 after N → `bg` after N+1 (2 cycles).
- `cpu_mem_busy` high stalls in IDLE. Arbitration happens at the first edge where it is low.
- Grant to release: `br[owner]` low at edge M → `bg`=0 after M → `bus_release`=0 after M+1.
- Steal mode: `bg` is high exactly MAX_BURST cycles, then 1 RETURN cycle, then CPU_SLOTS cycles with `bus_release`=0.
- Invariant: `bg`≠0 implies `bus_release`=1 in the same cycle and in the cycles immediately before and after. The CPU and a DMA channel never drive the bus together.
- `Reset` asserted in any state forces IDLE with all outputs 0 at that edge, even mid-burst. `grant_cnt` clears to 0.

## Structure
- Shared package / `opcodes.v`-style include: state encodings (`ARB_IDLE`…`ARB_CPU_SLOT`) and a `CLOG2` macro.
- Natural sub-module: `rr_picker`. It is combinational: inputs are `br` and `last_owner`; outputs are the winner index and `any`. It is reused later for a DMA-channel descriptor queue.
- `burst_cnt` is clog2(MAX_BURST)+1 bits. The CPU_SLOT counter is clog2(CPU_SLOTS)+1 bits.

## Test plan
- Reset, then `br`=4'b0100 with busy=0 → `bus_release`=1 at cycle 1, `bg`=4'b0100 at cycle 2, `owner`=2, `grant_cnt`=1. Drop `br` → `bg`=0 next cycle, `bus_release`=0 the cycle after.
- `br`=4'b1111 held, burst mode, each channel drops `br` after 3 grant cycles → grants issued in order 0,1,2,3,0, and `grant_cnt`=5.
- `steal_mode`=1, MAX_BURST=16, CPU_SLOTS=4, `br[1]` held → `bg[1]` high exactly 16 cycles, then 1 RETURN cycle, then 4 cycles of `bus_release`=0, then re-grant to channel 1 after HANDOFF.
- `cpu_mem_busy`=1 for 5 cycles with `br[3]`=1 → `bus_release` stays 0 for those 5 cycles, then the normal 2-cycle grant follows.
- `br[0]` pulses for one cycle only → HANDOFF then RETURN, `bg` never asserts, `grant_cnt` unchanged.
- `Reset` asserted mid-GRANT → all outputs 0 after that edge. The next request from channels 0 and 3 together grants channel 0.
